free_list: RTL and testbench
============================

Name: free_list

Overview:
- Circular pool of free physical register indices, SS lanes wide. Sits beside the ROB.
- Rename/dispatch takes SS free pregs per dispatch group.
- The commit path, which consumes ROB commit output, returns the stale physical register of each retired instruction.
- Holds NUM_PREGS-NUM_AREGS entries. On reset it is full with pregs NUM_AREGS..NUM_PREGS-1.

Parameters:
SS, 2, superscalar width (lanes per dequeue/enqueue)
NUM_PREGS, 64, physical register count
NUM_AREGS, 32, architectural register count; DEPTH = NUM_PREGS-NUM_AREGS
PREG_W, $clog2(NUM_PREGS), physical register index width

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high; clock clk
dequeue_req  in  1  rename consumes SS pregs this cycle (all-or-nothing)
free_preg  out  PREG_W x SS  pregs at head..head+SS-1, lane order
dequeue_ok  out  1  count >= SS; rename may dequeue
enqueue_valid  in  SS  per-lane return valid from commit (any subset)
enqueue_preg  in  PREG_W x SS  stale preg per lane
count  out  $clog2(DEPTH+1)  current occupancy
overflow_err  out  1  sticky: enqueue attempted beyond DEPTH
underflow_err  out  1  sticky: dequeue_req while !dequeue_ok

Behaviour:
- Storage: DEPTH-entry array; head and tail are $clog2(DEPTH)-bit pointers, modulo DEPTH (DEPTH is a power of two).
- Reset:
  - entry[i] = NUM_AREGS+i; head=0, tail=0, count=DEPTH.
  - overflow_err=0, underflow_err=0.
  - dequeue_ok=1 when DEPTH>=SS.
  - free_preg = NUM_AREGS..NUM_AREGS+SS-1.
  - rst mid-operation discards all state the next cycle.
- free_preg[i] = entry[head+i] (combinational read, wraps). Valid only when dequeue_ok. Lanes are never shown as X; garbage is allowed when !dequeue_ok.
- Dequeue, when dequeue_req && dequeue_ok: head <= head+SS and count decreases by SS. If !dequeue_ok, the request is ignored, underflow_err <= 1, and no state changes.
- Enqueue filtering: lane i is effective when enqueue_valid[i] && enqueue_preg[i] != 0. Preg 0 is the hardwired x0 mapping and is never freed.
- Enqueue compaction: effective lanes are written to tail, tail+1, ... in ascending lane order with no gaps. tail advances by the number of effective lanes (n_eff).
- Capacity: space = DEPTH - count + (SS if dequeue fires this cycle). If n_eff > space, only the first `space` effective lanes are written, the rest are dropped, and overflow_err <= 1.
- Simultaneous dequeue + enqueue:
  - Both complete in the same edge: count <= count - SS*deq + n_written.
  - dequeue_ok and free_preg use start-of-cycle state. A same-cycle enqueued preg is never dequeued in that cycle; there is no bypass.
- Wrap-around: head+i, tail+i and pointer advances all wrap modulo DEPTH. Full (count=DEPTH) and empty (count=0) are distinguished only by count, never by pointer equality.
- Latency: a returned preg becomes visible on free_preg one cycle after enqueue, provided it lands within head..head+SS-1.
- Errors are sticky until rst.
- No duplicate detection; commit is responsible for correctness.

Decomposition:
- Shared package (rv32i_types):
  - NUM_PREGS, NUM_AREGS, and the preg index typedef (preg_t).
  - free_list_enq_t {valid, preg} if commit bundles it.
- Sub-module lane_compactor: SS-bit valid mask in, produces per-lane write offsets and n_eff (prefix popcount). Combinational, reused by ROB commit.
- The rest is single-module RTL.

Test Plan:
- Reset, no activity -> count=32, dequeue_ok=1, free_preg={32,33}, both errors 0.
- 16 consecutive dequeue_req -> free_preg sequence {32,33},{34,35}...{62,63}; then count=0, dequeue_ok=0. A 17th request -> no state change, underflow_err=1.
- From empty, enqueue_valid=2'b10, enqueue_preg={lane0:5, lane1:7} -> count=1, entry[0]=7. Next cycle enqueue {9,0} with valid=2'b11 -> preg 0 dropped; count=2, free_preg={7,9}.
- Dequeue 2 from reset, then enqueue {40,41} in 16 cycles while dequeuing every cycle -> exercises the pointer wrap at DEPTH-1 to 0. count stays 30, and the order returned equals the order freed.
- At count=31, one dequeue and enqueue {3,4} in the same cycle -> count=31 (31-2+2), no overflow. At count=32 with no dequeue, enqueue {3,4} -> both dropped, overflow_err=1.
- Assert rst while count=10 mid-stream -> next cycle count=32, free_preg={32,33}, errors cleared.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared rename-stage types: register-file sizing and the commit-to-free-list return bundle.
package rv32i_types;
  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int PREG_W    = $clog2(NUM_PREGS);

  typedef logic [PREG_W-1:0] preg_t;

  typedef struct packed {
    logic  valid;
    preg_t preg;
  } free_list_enq_t;
endpackage

// File: rtl/lane_compactor.sv
// Prefix popcount over a lane mask: each lane's slot among the set lanes, plus the total set.
// Purely combinational; shared with the ROB commit path.
module lane_compactor #(
  parameter int SS    = 2,
  parameter int CNT_W = $clog2(SS + 1)
) (
  input  logic [SS-1:0]            mask,
  output logic [SS-1:0][CNT_W-1:0] offset,
  output logic [CNT_W-1:0]         n_eff
);

  logic [CNT_W-1:0] acc;

  always_comb begin
    acc    = '0;
    offset = '0;
    for (int i = 0; i < SS; i++) begin
      offset[i] = acc;
      acc       = acc + CNT_W'(mask[i]);
    end
    n_eff = acc;
  end

endmodule

// File: rtl/free_list.sv
// Circular pool of free physical registers: rename dequeues SS at a time, commit returns stale pregs.
// Occupancy is tracked by count alone so full and empty never rely on pointer equality.
module free_list #(
  parameter int SS        = 2,
  parameter int NUM_PREGS = rv32i_types::NUM_PREGS,
  parameter int NUM_AREGS = rv32i_types::NUM_AREGS,
  parameter int PREG_W    = $clog2(NUM_PREGS),
  parameter int DEPTH     = NUM_PREGS - NUM_AREGS,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        dequeue_req,
  output logic [SS-1:0][PREG_W-1:0]   free_preg,
  output logic                        dequeue_ok,
  input  logic [SS-1:0]               enqueue_valid,
  input  logic [SS-1:0][PREG_W-1:0]   enqueue_preg,
  output logic [CNT_W-1:0]            count,
  output logic                        overflow_err,
  output logic                        underflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SP_W  = CNT_W + 1;
  localparam int LN_W  = $clog2(SS + 1);

  logic [PREG_W-1:0]         entry [DEPTH];
  logic [PTR_W-1:0]          head;
  logic [PTR_W-1:0]          tail;

  logic [SS-1:0]             eff_mask;
  logic [SS-1:0][LN_W-1:0]   lane_off;
  logic [LN_W-1:0]           n_eff;
  logic [SS-1:0]             lane_wr;
  logic                      deq_fire;
  logic                      ovf_now;
  logic [SP_W-1:0]           space;
  logic [SP_W-1:0]           n_wr;
  logic [SP_W-1:0]           count_nxt;

  // Preg 0 is the hardwired x0 mapping and must never re-enter the pool.
  always_comb begin
    eff_mask = '0;
    for (int i = 0; i < SS; i++)
      eff_mask[i] = enqueue_valid[i] && (enqueue_preg[i] != '0);
  end

  lane_compactor #(.SS(SS), .CNT_W(LN_W)) u_compact (
    .mask   (eff_mask),
    .offset (lane_off),
    .n_eff  (n_eff)
  );

  assign dequeue_ok = (count >= CNT_W'(SS));
  assign deq_fire   = dequeue_req && dequeue_ok;

  // Slots freed by a same-cycle dequeue may be refilled on this edge.
  always_comb begin
    space     = SP_W'(DEPTH) - SP_W'(count) + (deq_fire ? SP_W'(SS) : '0);
    ovf_now   = SP_W'(n_eff) > space;
    n_wr      = ovf_now ? space : SP_W'(n_eff);
    count_nxt = SP_W'(count) - (deq_fire ? SP_W'(SS) : '0) + n_wr;
    lane_wr   = '0;
    for (int i = 0; i < SS; i++)
      lane_wr[i] = eff_mask[i] && (SP_W'(lane_off[i]) < space);
  end

  always_comb begin
    free_preg = '0;
    for (int i = 0; i < SS; i++)
      free_preg[i] = entry[head + PTR_W'(i)];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        entry[i] <= PREG_W'(NUM_AREGS + i);
      head          <= '0;
      tail          <= '0;
      count         <= CNT_W'(DEPTH);
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      for (int i = 0; i < SS; i++)
        if (lane_wr[i])
          entry[tail + PTR_W'(lane_off[i])] <= enqueue_preg[i];
      if (deq_fire)
        head <= head + PTR_W'(SS);
      tail  <= tail + PTR_W'(n_wr);
      count <= CNT_W'(count_nxt);
      if (ovf_now)
        overflow_err <= 1'b1;
      if (dequeue_req && !dequeue_ok)
        underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Directed table plus hand sequences for free_list (SS=2, 64 pregs, 32 aregs).
module tb_free_list;

  logic            clk = 1'b0;
  logic            rst;
  logic            dequeue_req;
  logic [1:0][5:0] free_preg;
  logic            dequeue_ok;
  logic [1:0]      enqueue_valid;
  logic [1:0][5:0] enqueue_preg;
  logic [5:0]      count;
  logic            overflow_err;
  logic            underflow_err;

  int nchk = 0;
  int nerr = 0;

  free_list dut (
    .clk           (clk),
    .rst           (rst),
    .dequeue_req   (dequeue_req),
    .free_preg     (free_preg),
    .dequeue_ok    (dequeue_ok),
    .enqueue_valid (enqueue_valid),
    .enqueue_preg  (enqueue_preg),
    .count         (count),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       deq;
    logic [1:0] ev;
    int         p0, p1;
    int         cnt;
    logic       chk_f;
    int         f0, f1;
    logic       ok, ov, un;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dequeue_req   = 1'b0;
    enqueue_valid = 2'b00;
    enqueue_preg  = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_state(input string tag, input int c, input int ok, input int ov, input int un);
    chk({tag, " count"}, int'(count), c);
    chk({tag, " dequeue_ok"}, int'(dequeue_ok), ok);
    chk({tag, " overflow_err"}, int'(overflow_err), ov);
    chk({tag, " underflow_err"}, int'(underflow_err), un);
  endtask

  task automatic chk_free(input string tag, input int f0, input int f1);
    chk({tag, " free_preg[0]"}, int'(free_preg[0]), f0);
    chk({tag, " free_preg[1]"}, int'(free_preg[1]), f1);
  endtask

  initial begin
    int q[$];
    int freed[$];
    int a, b;

    // Drain from full, one extra request, then refill from empty.
    for (int k = 0; k < 16; k++)
      tbl[k] = '{deq: 1'b1, ev: 2'b00, p0: 0, p1: 0, cnt: 30 - 2*k, chk_f: (k < 15),
                 f0: 34 + 2*k, f1: 35 + 2*k, ok: (k < 15), ov: 1'b0, un: 1'b0};
    tbl[16] = '{deq: 1'b1, ev: 2'b00, p0: 0, p1: 0, cnt: 0, chk_f: 1'b0,
                f0: 0, f1: 0, ok: 1'b0, ov: 1'b0, un: 1'b1};
    tbl[17] = '{deq: 1'b0, ev: 2'b10, p0: 5, p1: 7, cnt: 1, chk_f: 1'b0,
                f0: 0, f1: 0, ok: 1'b0, ov: 1'b0, un: 1'b1};
    tbl[18] = '{deq: 1'b0, ev: 2'b11, p0: 9, p1: 0, cnt: 2, chk_f: 1'b1,
                f0: 7, f1: 9, ok: 1'b1, ov: 1'b0, un: 1'b1};

    do_reset();
    step();
    chk_state("reset", 32, 1, 0, 0);
    chk_free("reset", 32, 33);

    for (int k = 0; k < 19; k++) begin
      dequeue_req     = tbl[k].deq;
      enqueue_valid   = tbl[k].ev;
      enqueue_preg[0] = 6'(tbl[k].p0);
      enqueue_preg[1] = 6'(tbl[k].p1);
      step();
      chk_state($sformatf("vec%0d", k), tbl[k].cnt, int'(tbl[k].ok), int'(tbl[k].ov), int'(tbl[k].un));
      if (tbl[k].chk_f)
        chk_free($sformatf("vec%0d", k), tbl[k].f0, tbl[k].f1);
    end

    // Steady state: recycle freed pregs in order while dequeuing every cycle, across the wrap.
    do_reset();
    for (int i = 32; i < 64; i++) q.push_back(i);
    dequeue_req = 1'b1;
    step();
    freed.push_back(q.pop_front());
    freed.push_back(q.pop_front());
    chk_state("wrap0", 30, 1, 0, 0);
    chk_free("wrap0", q[0], q[1]);
    for (int k = 0; k < 20; k++) begin
      dequeue_req     = 1'b1;
      enqueue_valid   = 2'b11;
      a               = freed.pop_front();
      b               = freed.pop_front();
      enqueue_preg[0] = 6'(a);
      enqueue_preg[1] = 6'(b);
      freed.push_back(q.pop_front());
      freed.push_back(q.pop_front());
      q.push_back(a);
      q.push_back(b);
      step();
      chk($sformatf("wrap%0d count", k + 1), int'(count), 30);
      chk_free($sformatf("wrap%0d", k + 1), q[0], q[1]);
    end
    chk_state("wrap_end", 30, 1, 0, 0);

    // Near-full: simultaneous dequeue+enqueue fits; enqueue into a full pool overflows.
    do_reset();
    dequeue_req = 1'b1;
    step();
    dequeue_req     = 1'b0;
    enqueue_valid   = 2'b01;
    enqueue_preg[0] = 6'd10;
    step();
    chk_state("fill31", 31, 1, 0, 0);
    dequeue_req     = 1'b1;
    enqueue_valid   = 2'b11;
    enqueue_preg[0] = 6'd3;
    enqueue_preg[1] = 6'd4;
    step();
    chk_state("deq_enq31", 31, 1, 0, 0);
    chk_free("deq_enq31", 36, 37);
    dequeue_req     = 1'b0;
    enqueue_valid   = 2'b01;
    enqueue_preg[0] = 6'd5;
    step();
    chk_state("fill32", 32, 1, 0, 0);
    enqueue_valid   = 2'b11;
    enqueue_preg[0] = 6'd3;
    enqueue_preg[1] = 6'd4;
    step();
    chk_state("full_enq", 32, 1, 1, 0);

    // Reset mid-stream must discard pool contents and sticky errors.
    idle();
    dequeue_req = 1'b1;
    for (int k = 0; k < 11; k++) step();
    chk_state("mid", 10, 1, 1, 0);
    rst           = 1'b1;
    enqueue_valid = 2'b11;
    enqueue_preg[0] = 6'd12;
    enqueue_preg[1] = 6'd13;
    step();
    rst = 1'b0;
    idle();
    chk_state("rst_mid", 32, 1, 0, 0);
    chk_free("rst_mid", 32, 33);
    step();
    chk_state("rst_idle", 32, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
